// File: rtl/bp_me_wb_master_pkg.sv
// Shared BedRock message types, header layout and bridge state encoding
// for the BedRock-to-Wishbone master bridge.
package bp_me_wb_master_pkg;

  localparam int paddr_width_gp   = 40;
  localparam int payload_width_gp = 24;
  localparam int dword_width_gp   = 64;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [payload_width_gp-1:0] payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_mem_header_s;

  localparam int mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

  typedef enum logic [1:0] {e_ready, e_wb, e_resp} bp_me_wb_master_state_e;

endpackage

// File: rtl/bp_me_wb_master_bus_pack.sv
// Picks the addressed sub-word out of a bus-wide value and replicates it
// across the whole bus; sizes at or above the bus width pass through.
module bp_me_wb_master_bus_pack
  import bp_me_wb_master_pkg::*;
#(
  parameter int data_width_p = dword_width_gp,
  localparam int lg_bytes_lp = $clog2(data_width_p/8),
  localparam int off_width_lp = (lg_bytes_lp == 0) ? 1 : lg_bytes_lp
) (
  input  logic [data_width_p-1:0] data_i,
  input  logic [off_width_lp-1:0] sel_i,
  input  bp_bedrock_msg_size_e    size_i,
  output logic [data_width_p-1:0] data_o
);

  logic [data_width_p-1:0] shifted;
  logic [data_width_p-1:0] rep [lg_bytes_lp+1];

  assign shifted = data_i >> {sel_i, 3'b000};

  for (genvar gi = 0; gi <= lg_bytes_lp; gi++) begin : g_size
    localparam int sw_lp = 8 << gi;
    assign rep[gi] = {(data_width_p/sw_lp){shifted[sw_lp-1:0]}};
  end

  always_comb begin
    data_o = rep[lg_bytes_lp];
    for (int i = 0; i < lg_bytes_lp; i++) begin
      if (size_i == 3'(i)) data_o = rep[i];
    end
  end

endmodule

// File: rtl/bp_me_wb_master.sv
// BedRock mem_fwd/mem_rev to Wishbone B4 classic master bridge; one
// single-beat uncached transaction in flight, with optional ack timeout.
module bp_me_wb_master
  import bp_me_wb_master_pkg::*;
#(
  parameter int data_width_p = dword_width_gp,
  parameter int timeout_p    = 1024,
  localparam int lg_bytes_lp     = $clog2(data_width_p/8),
  localparam int wb_adr_width_lp = paddr_width_gp - lg_bytes_lp,
  localparam int wb_sel_width_lp = data_width_p/8
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic [mem_header_width_gp-1:0] mem_fwd_header_i,
  input  logic [data_width_p-1:0]        mem_fwd_data_i,
  input  logic                           mem_fwd_v_i,
  output logic                           mem_fwd_ready_and_o,
  input  logic                           mem_fwd_last_i,
  output logic [mem_header_width_gp-1:0] mem_rev_header_o,
  output logic [data_width_p-1:0]        mem_rev_data_o,
  output logic                           mem_rev_v_o,
  input  logic                           mem_rev_ready_and_i,
  output logic                           mem_rev_last_o,
  output logic [wb_adr_width_lp-1:0]     adr_o,
  output logic [data_width_p-1:0]        dat_o,
  output logic                           cyc_o,
  output logic                           stb_o,
  output logic [wb_sel_width_lp-1:0]     sel_o,
  output logic                           we_o,
  input  logic [data_width_p-1:0]        dat_i,
  input  logic                           ack_i,
  input  logic                           err_i
);

  localparam int off_width_lp   = (lg_bytes_lp == 0) ? 1 : lg_bytes_lp;
  localparam int timer_width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam bit width_ok_lp    = (data_width_p == 8) || (data_width_p == 16)
                                || (data_width_p == 32) || (data_width_p == 64);

  bp_me_wb_master_state_e  state_q, state_d;
  bp_bedrock_mem_header_s  hdr_q, hdr_d, fwd_hdr;
  logic [data_width_p-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [timer_width_lp-1:0] timer_q, timer_d;
  logic [off_width_lp-1:0]   offset;
  logic [wb_sel_width_lp-1:0] sel;
  logic fwd_is_uc, is_rd, wb_active, timeout_hit, wb_done;

  assign fwd_hdr     = bp_bedrock_mem_header_s'(mem_fwd_header_i);
  assign fwd_is_uc   = (fwd_hdr.msg_type == e_bedrock_mem_uc_rd)
                     || (fwd_hdr.msg_type == e_bedrock_mem_uc_wr);
  assign is_rd       = hdr_q.msg_type == e_bedrock_mem_uc_rd;
  assign wb_active   = state_q == e_wb;
  assign offset      = hdr_q.addr[off_width_lp-1:0] & off_width_lp'(wb_sel_width_lp - 1);
  assign timeout_hit = (timeout_p != 0) && (timer_q == timer_width_lp'(timeout_p - 1));
  assign wb_done     = ack_i | err_i | timeout_hit;

  // Sub-bus sizes select a contiguous byte lane group; anything wider selects all lanes.
  always_comb begin
    sel = '1;
    if (hdr_q.size < 3'(lg_bytes_lp)) begin
      sel = wb_sel_width_lp'((32'd1 << (32'd1 << hdr_q.size)) - 32'd1) << offset;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= e_ready;
      hdr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    timer_d = timer_q;
    unique case (state_q)
      e_ready: if (mem_fwd_v_i) begin
        hdr_d   = fwd_hdr;
        wdata_d = mem_fwd_data_i;
        rdata_d = '0;
        timer_d = '0;
        state_d = fwd_is_uc ? e_wb : e_resp;
      end
      e_wb: begin
        timer_d = timer_q + 1'b1;
        if (wb_done) begin
          // Error wins over a simultaneous ack; timeouts also return zero.
          rdata_d = (is_rd && ack_i && !err_i) ? dat_i : '0;
          state_d = e_resp;
        end
      end
      e_resp: if (mem_rev_ready_and_i) state_d = e_ready;
      default: state_d = e_ready;
    endcase
  end

  assign mem_fwd_ready_and_o = state_q == e_ready;
  assign cyc_o            = wb_active;
  assign stb_o            = wb_active;
  assign we_o             = wb_active && (hdr_q.msg_type == e_bedrock_mem_uc_wr);
  assign adr_o            = wb_active ? hdr_q.addr[paddr_width_gp-1:lg_bytes_lp] : '0;
  assign dat_o            = wb_active ? wdata_q : '0;
  assign sel_o            = wb_active ? sel : '0;
  assign mem_rev_v_o      = state_q == e_resp;
  assign mem_rev_header_o = hdr_q;
  assign mem_rev_last_o   = 1'b1;

  bp_me_wb_master_bus_pack #(.data_width_p(data_width_p)) u_pack (
    .data_i(rdata_q),
    .sel_i (offset),
    .size_i(hdr_q.size),
    .data_o(mem_rev_data_o)
  );

  assert property (@(posedge clk_i) width_ok_lp);
  assert property (@(posedge clk_i) disable iff (!reset_ni) mem_fwd_v_i |-> mem_fwd_last_i);

endmodule
